// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the RV32I core, with a bounded memory-ready wait.
// Optional feature: define ILLEGAL_TRAP_EN to halt in a sticky TRAP state on an unknown opcode.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic       mem_timeout,
    output logic       illegal
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Last counter value before the limit: the wait is aborted in the cycle that would reach it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             wait_st_s, timeout_s, mem_timeout_r;
    logic             mem_read_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s;
    logic [1:0]       imm_src_s, alu_src_a_s, alu_src_b_s, result_src_s;
    logic [2:0]       alu_control_s;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_r;
`endif

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [2:0] alu;
        case (f3)
            3'b000:  alu = (is_r && f7b5) ? 3'b001 : 3'b000;
            3'b010:  alu = 3'b101;
            3'b110:  alu = 3'b011;
            3'b111:  alu = 3'b010;
            default: alu = 3'b000;
        endcase
        return alu;
    endfunction

    assign wait_st_s = (state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE);
    assign timeout_s = wait_st_s && !mem_ready && (cnt_r == CNT_LAST);

    // Next-state and memory-wait counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = {CNT_W{1'b0}};
        if (wait_st_s && !mem_ready && !timeout_s) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = {CNT_W{1'b0}};
        end
        case (state_r)
            S_FETCH:    state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_s = S_MEMADR;
                    OP_R:         state_s = S_EXEC_R;
                    OP_I:         state_s = S_EXEC_I;
                    OP_JAL:       state_s = S_JAL;
                    OP_BEQ:       state_s = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_s = S_TRAP;
`else
                    default:      state_s = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_s = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_s = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_s = S_FETCH;
            S_MEMWRITE: state_s = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   state_s = S_ALUWB;
            S_EXEC_I:   state_s = S_ALUWB;
            S_ALUWB:    state_s = S_FETCH;
            S_JAL:      state_s = S_ALUWB;
            S_BEQ:      state_s = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_s = S_TRAP;
`endif
            default:    state_s = S_FETCH;
        endcase
        if (timeout_s) begin
            state_s = S_FETCH;
        end else begin
            state_s = state_s;
        end
    end

    // State, counter and status flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_FETCH;
            cnt_r         <= {CNT_W{1'b0}};
            mem_timeout_r <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            mem_timeout_r <= timeout_s;
`ifdef ILLEGAL_TRAP_EN
            illegal_r     <= illegal_r | (state_s == S_TRAP);
`endif
        end
    end

    // Moore output decode; pc_write and ir_write also qualified by mem_ready/zero
    always_comb begin
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        adr_src_s     = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        imm_src_s     = 2'b00;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = 3'b000;
        result_src_s  = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_read_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                imm_src_s   = 2'b10;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                imm_src_s   = (op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                mem_read_s = 1'b1;
                adr_src_s  = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = alu_dec(funct3, funct7b5, 1'b1);
            end
            S_EXEC_I: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_dec(funct3, funct7b5, 1'b0);
            end
            S_ALUWB:  reg_write_s = 1'b1;
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                imm_src_s   = 2'b11;
                pc_write_s  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = 3'b001;
                pc_write_s    = zero;
            end
            default: mem_read_s = 1'b0;
        endcase
    end

    // Holding reset forces every request and select low, whatever the state register shows.
    assign mem_read    = mem_read_s  & rst_n;
    assign mem_write   = mem_write_s & rst_n;
    assign adr_src     = adr_src_s   & rst_n;
    assign ir_write    = ir_write_s  & rst_n;
    assign pc_write    = pc_write_s  & rst_n;
    assign reg_write   = reg_write_s & rst_n;
    assign imm_src     = rst_n ? imm_src_s     : 2'b00;
    assign alu_src_a   = rst_n ? alu_src_a_s   : 2'b00;
    assign alu_src_b   = rst_n ? alu_src_b_s   : 2'b00;
    assign alu_control = rst_n ? alu_control_s : 3'b000;
    assign result_src  = rst_n ? result_src_s  : 2'b00;
    assign mem_timeout = mem_timeout_r;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = illegal_r;
`else
    assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written timeout, reset and illegal-op sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, mem_timeout, illegal;
    logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.TIMEOUT_CYC(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .imm_src(imm_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .result_src(result_src), .mem_timeout(mem_timeout), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t vq[$];

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] JL = 7'b1101111, BQ = 7'b1100011, BAD = 7'b0000000;

    logic [18:0] e_fetch, e_fetch_w, e_to, e_dec, e_ma_lw, e_ma_sw, e_mrd, e_mwb, e_mwr;
    logic [18:0] e_aluwb, e_jal, e_beq1, e_beq0, e_zero, e_trap;

    // Field order: mr mw as irw pcw rw imm a b alu res timeout illegal
    function automatic logic [18:0] pk(input logic mr, input logic mw, input logic as_, input logic irw,
                                       input logic pcw, input logic rw, input logic [1:0] imm,
                                       input logic [1:0] a, input logic [1:0] b, input logic [2:0] alu,
                                       input logic [1:0] res, input logic to, input logic ill);
        return {mr, mw, as_, irw, pcw, rw, imm, a, b, alu, res, to, ill};
    endfunction

    function automatic logic [18:0] e_exr(input logic [2:0] alu);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] e_exi(input logic [2:0] alu);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic void add(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input logic r, input logic [18:0] e);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = r; v.exp = e;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [18:0] e);
        logic [18:0] act;
        act = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, imm_src, alu_src_a,
               alu_src_b, alu_control, result_src, mem_timeout, illegal};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", nm, act, e);
        end
    endtask

    // Drive inputs just after a rising edge, compare on the falling edge, advance one clock.
    task automatic cyc(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic r, input logic [18:0] e);
        op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = r;
        @(negedge clk);
        chk(nm, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_fetch   = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0);
        e_fetch_w = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0);
        e_to      = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 1'b1, 1'b0);
        e_dec     = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
        e_ma_lw   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
        e_ma_sw   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
        e_mrd     = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
        e_mwb     = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
        e_mwr     = pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
        e_aluwb   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
        e_jal     = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0);
        e_beq1    = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0);
        e_beq0    = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0);
        e_zero    = 19'd0;
        e_trap    = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);

        // lw x5,8(x1): FETCH DECODE MEMADR MEMREAD MEMWB
        add(LW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch);
        add(LW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec);
        add(LW, 3'b010, 1'b0, 1'b0, 1'b1, e_ma_lw);
        add(LW, 3'b010, 1'b0, 1'b0, 1'b1, e_mrd);
        add(LW, 3'b010, 1'b0, 1'b0, 1'b1, e_mwb);
        // sw: three stalled MEMWRITE cycles, then completion
        add(SW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch);
        add(SW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec);
        add(SW, 3'b010, 1'b0, 1'b0, 1'b1, e_ma_sw);
        add(SW, 3'b010, 1'b0, 1'b0, 1'b0, e_mwr);
        add(SW, 3'b010, 1'b0, 1'b0, 1'b0, e_mwr);
        add(SW, 3'b010, 1'b0, 1'b0, 1'b0, e_mwr);
        add(SW, 3'b010, 1'b0, 1'b0, 1'b1, e_mwr);
        // R-type: add, sub, slt, or, and, xor(->add)
        add(RT, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch);
        add(RT, 3'b000, 1'b0, 1'b0, 1'b1, e_dec);
        add(RT, 3'b000, 1'b0, 1'b0, 1'b1, e_exr(3'b000));
        add(RT, 3'b000, 1'b0, 1'b0, 1'b1, e_aluwb);
        add(RT, 3'b000, 1'b1, 1'b0, 1'b1, e_fetch);
        add(RT, 3'b000, 1'b1, 1'b0, 1'b1, e_dec);
        add(RT, 3'b000, 1'b1, 1'b0, 1'b1, e_exr(3'b001));
        add(RT, 3'b000, 1'b1, 1'b0, 1'b1, e_aluwb);
        add(RT, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch);
        add(RT, 3'b010, 1'b0, 1'b0, 1'b1, e_dec);
        add(RT, 3'b010, 1'b0, 1'b0, 1'b1, e_exr(3'b101));
        add(RT, 3'b010, 1'b0, 1'b0, 1'b1, e_aluwb);
        add(RT, 3'b110, 1'b0, 1'b0, 1'b1, e_fetch);
        add(RT, 3'b110, 1'b0, 1'b0, 1'b1, e_dec);
        add(RT, 3'b110, 1'b0, 1'b0, 1'b1, e_exr(3'b011));
        add(RT, 3'b110, 1'b0, 1'b0, 1'b1, e_aluwb);
        add(RT, 3'b111, 1'b0, 1'b0, 1'b1, e_fetch);
        add(RT, 3'b111, 1'b0, 1'b0, 1'b1, e_dec);
        add(RT, 3'b111, 1'b0, 1'b0, 1'b1, e_exr(3'b010));
        add(RT, 3'b111, 1'b0, 1'b0, 1'b1, e_aluwb);
        add(RT, 3'b100, 1'b0, 1'b0, 1'b1, e_fetch);
        add(RT, 3'b100, 1'b0, 1'b0, 1'b1, e_dec);
        add(RT, 3'b100, 1'b0, 1'b0, 1'b1, e_exr(3'b000));
        add(RT, 3'b100, 1'b0, 1'b0, 1'b1, e_aluwb);
        // addi with instr[30]=1 stays add; slti
        add(IT, 3'b000, 1'b1, 1'b0, 1'b1, e_fetch);
        add(IT, 3'b000, 1'b1, 1'b0, 1'b1, e_dec);
        add(IT, 3'b000, 1'b1, 1'b0, 1'b1, e_exi(3'b000));
        add(IT, 3'b000, 1'b1, 1'b0, 1'b1, e_aluwb);
        add(IT, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch);
        add(IT, 3'b010, 1'b0, 1'b0, 1'b1, e_dec);
        add(IT, 3'b010, 1'b0, 1'b0, 1'b1, e_exi(3'b101));
        add(IT, 3'b010, 1'b0, 1'b0, 1'b1, e_aluwb);
        // beq taken, beq not taken, jal
        add(BQ, 3'b000, 1'b0, 1'b1, 1'b1, e_fetch);
        add(BQ, 3'b000, 1'b0, 1'b1, 1'b1, e_dec);
        add(BQ, 3'b000, 1'b0, 1'b1, 1'b1, e_beq1);
        add(BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch);
        add(BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_dec);
        add(BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_beq0);
        add(JL, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch);
        add(JL, 3'b000, 1'b0, 1'b0, 1'b1, e_dec);
        add(JL, 3'b000, 1'b0, 1'b0, 1'b1, e_jal);
        add(JL, 3'b000, 1'b0, 1'b0, 1'b1, e_aluwb);

        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("reset_outputs", e_zero);
        @(negedge clk);
        chk("reset_hold", e_zero);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            cyc($sformatf("vec%0d", i), vq[i].op, vq[i].f3, vq[i].f7, vq[i].z, vq[i].rdy, vq[i].exp);
        end

        // Fetch stall: 15 waiting cycles abort, then mem_ready on the limit cycle completes normally
        for (int i = 1; i <= 15; i++) cyc($sformatf("to_wait%0d", i), BQ, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch_w);
        cyc("to_pulse", BQ, 3'b000, 1'b0, 1'b0, 1'b0, e_to);
        for (int i = 2; i <= 14; i++) cyc($sformatf("rewait%0d", i), BQ, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch_w);
        cyc("limit_ready", BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch);
        cyc("limit_decode", BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_dec);
        cyc("limit_beq", BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_beq0);

        // Reset in MEMREAD aborts the load; a full lw then completes
        cyc("rl_fetch", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch);
        cyc("rl_dec", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec);
        cyc("rl_ma", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_ma_lw);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rl_memread", e_mrd);
        #1 rst_n = 1'b0;
        #1 chk("rl_rst_now", e_zero);
        @(posedge clk);
        #1 chk("rl_rst_edge", e_zero);
        rst_n = 1'b1;
        cyc("rl_after_fetch", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch);
        cyc("rl_after_dec", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec);
        cyc("rl_after_ma", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_ma_lw);
        cyc("rl_after_mrd", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_mrd);
        cyc("rl_after_mwb", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_mwb);

        // Unknown opcode
        cyc("bad_fetch", BAD, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch);
        cyc("bad_dec", BAD, 3'b000, 1'b0, 1'b0, 1'b1, e_dec);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc($sformatf("trap%0d", i), LW, 3'b000, 1'b0, 1'b1, 1'b1, e_trap);
        rst_n = 1'b0;
        #1 chk("trap_rst", e_zero);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("trap_released", LW, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch_w);
`else
        cyc("bad_nop_fetch", BAD, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch_w);
        cyc("bad_nop_fetch2", BAD, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch_w);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
